tcm_mem_responder: RTL

Address-decoding memory responder for the CoralNPU UVM environment and standalone RTL benches. Accepts word requests on a valid/ready channel and classifies each address as ITCM, DTCM, CSR or unmapped using the system memory map. It services ITCM/DTCM from internal arrays and CSR from a small register file. Responses return in order through a bounded response FIFO with error signalling.

---
 rtl/memory_map_pkg.sv | 24 ++
 rtl/tcm_responder_pkg.sv | 28 ++
 rtl/tcm_mem_responder_if.sv | 28 ++
 rtl/tcm_rsp_fifo.sv | 63 ++++++
 rtl/tcm_mem_responder.sv | 104 ++++++++++
 5 files changed

// File: rtl/memory_map_pkg.sv
// System memory map shared by the CoralNPU benches: region bounds and membership tests.
package memory_map_pkg;

  localparam logic [31:0] ITCM_START_ADDR = 32'h0000_0000;
  localparam logic [31:0] ITCM_END_ADDR   = 32'h0000_1FFF;
  localparam logic [31:0] DTCM_START_ADDR = 32'h0001_0000;
  localparam logic [31:0] DTCM_END_ADDR   = 32'h0001_7FFF;
  localparam logic [31:0] CSR_START_ADDR  = 32'h0003_0000;
  localparam logic [31:0] CSR_END_ADDR    = 32'h0003_FFFF;

  // Offset-from-base form keeps the comparisons correct even for a zero base.
  function automatic logic is_in_itcm(input logic [31:0] addr);
    return (addr - ITCM_START_ADDR) <= (ITCM_END_ADDR - ITCM_START_ADDR);
  endfunction

  function automatic logic is_in_dtcm(input logic [31:0] addr);
    return (addr - DTCM_START_ADDR) <= (DTCM_END_ADDR - DTCM_START_ADDR);
  endfunction

  function automatic logic is_in_csr(input logic [31:0] addr);
    return (addr - CSR_START_ADDR) <= (CSR_END_ADDR - CSR_START_ADDR);
  endfunction

endpackage

// File: rtl/tcm_responder_pkg.sv
// Types shared by the TCM memory responder: region tags and the queued response word.
package tcm_responder_pkg;
  import memory_map_pkg::*;

  localparam int TAG_W = 4;

  typedef enum logic [1:0] {
    REGION_ITCM = 2'd0,
    REGION_DTCM = 2'd1,
    REGION_CSR  = 2'd2,
    REGION_NONE = 2'd3
  } region_e;

  typedef struct packed {
    logic [TAG_W-1:0] id;
    region_e          region;
    logic             err;
    logic [31:0]      rdata;
  } rsp_t;

  function automatic region_e decode_region(input logic [31:0] addr);
    if (is_in_itcm(addr)) return REGION_ITCM;
    if (is_in_dtcm(addr)) return REGION_DTCM;
    if (is_in_csr(addr))  return REGION_CSR;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/tcm_mem_responder_if.sv
// Request/response channel between a requester (master) and the TCM responder (slave).
interface tcm_mem_responder_if #(
  parameter int ID_W = tcm_responder_pkg::TAG_W
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [31:0]     req_addr_i;
  logic            req_we_i;
  logic [31:0]     req_wdata_i;
  logic [3:0]      req_be_i;
  logic [ID_W-1:0] req_id_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o;
  logic [1:0]      rsp_region_o;
  logic [ID_W-1:0] rsp_id_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, req_id_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_region_o, rsp_id_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, req_id_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_region_o, rsp_id_o
  );
endinterface

// File: rtl/tcm_rsp_fifo.sv
// In-order response queue; an empty queue presents an all-zero head.
module tcm_rsp_fifo
  import tcm_responder_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  rsp_t             data_i,
  input  logic             pop_i,
  output rsp_t             data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push_i && (count_q != CNT_W'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/tcm_mem_responder.sv
// Word-access responder: decodes ITCM/DTCM/CSR, services the access at the acceptance
// edge and queues the response for in-order return.
module tcm_mem_responder
  import tcm_responder_pkg::*;
#(
  parameter int RSP_DEPTH = 2,
  parameter int CSR_REGS  = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  tcm_mem_responder_if.slave bus
);

  localparam int CSR_IDX_W = (CSR_REGS > 1) ? $clog2(CSR_REGS) : 1;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  logic [31:0] itcm_mem [2048];
  logic [31:0] dtcm_mem [8192];
  logic [31:0] csr_q [CSR_REGS];
  logic [31:0] csr_d [CSR_REGS];

  region_e              req_region;
  logic                 req_err, req_fire, req_ready, csr_hit, wr_ok;
  logic [10:0]          itcm_idx;
  logic [12:0]          dtcm_idx;
  logic [CSR_IDX_W-1:0] csr_idx;
  logic [31:0]          rd_word, be_mask;
  rsp_t                 push_rsp, head_rsp;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;

  assign itcm_idx = bus.req_addr_i[12:2];
  assign dtcm_idx = bus.req_addr_i[14:2];
  assign csr_idx  = bus.req_addr_i[2 +: CSR_IDX_W];

  // Decode, error classification and read data all settle before the acceptance edge.
  always_comb begin
    req_region = decode_region(bus.req_addr_i);
    req_err    = (req_region == REGION_NONE) || (bus.req_addr_i[1:0] != 2'b00);
    csr_hit    = {18'd0, bus.req_addr_i[15:2]} < 32'(CSR_REGS);
    req_fire   = bus.req_valid_i && req_ready;
    wr_ok      = req_fire && bus.req_we_i && !req_err;
    be_mask    = '0;
    for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{bus.req_be_i[b]}};
    rd_word = '0;
    case (req_region)
      REGION_ITCM: rd_word = itcm_mem[itcm_idx];
      REGION_DTCM: rd_word = dtcm_mem[dtcm_idx];
      REGION_CSR:  rd_word = csr_hit ? csr_q[csr_idx] : '0;
      default:     rd_word = '0;
    endcase
    push_rsp.id     = bus.req_id_i;
    push_rsp.region = req_region;
    push_rsp.err    = req_err;
    push_rsp.rdata  = (req_err || bus.req_we_i) ? '0 : rd_word;
  end

  always_comb begin
    csr_d = csr_q;
    if (wr_ok && (req_region == REGION_CSR) && csr_hit)
      csr_d[csr_idx] = (csr_q[csr_idx] & ~be_mask) | (bus.req_wdata_i & be_mask);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) csr_q <= '{default: '0};
    else       csr_q <= csr_d;
  end

  // TCM arrays are never reset; a request seen on the reset edge must not write them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_be_i[b]) begin
          if (req_region == REGION_ITCM) itcm_mem[itcm_idx][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
          if (req_region == REGION_DTCM) dtcm_mem[dtcm_idx][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  tcm_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_fire),
    .data_i  (push_rsp),
    .pop_i   (bus.rsp_ready_i),
    .data_o  (head_rsp),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_ready        = !fifo_full;
  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = !fifo_empty;
  assign bus.rsp_rdata_o  = head_rsp.rdata;
  assign bus.rsp_err_o    = head_rsp.err;
  assign bus.rsp_region_o = head_rsp.region;
  assign bus.rsp_id_o     = head_rsp.id;

  assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_full == (fifo_count == CNT_W'(RSP_DEPTH)));

endmodule
